bram_sdp: RTL and testbench

Parametrised simple-dual-port block RAM with one write port and one read port. It is the next-generation storage primitive for the user-project datapaths (FIR tap and data buffers), replacing the fixed 11×32 RAM. New behaviour:
- byte write enables
- read-during-write bypass
- out-of-range detection
- a hardware clear sequencer that zeroes the array after reset or on request

---
 rtl/bram_pkg.sv | 35 +++
 rtl/bram_sdp_if.sv | 40 ++++
 rtl/bram_clr_seq.sv | 65 ++++++
 rtl/bram_sdp.sv | 129 ++++++++++++
 tb/tb_bram_sdp.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and helpers for the bram_sdp storage primitive
//
// Purpose : FSM state type for the clear sequencer and the byte-lane merge
//           used by both the array write path and the read-during-write bypass.
// Ports   : none (package).
// Config  : none; BRAM_SDP_OUTREG_EN is consumed by rtl/bram_sdp.sv.

package bram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } bram_state_t;

   // The merge works on a fixed, generous width so a single function serves
   // every DATA_WIDTH; callers size-cast in and out.
   localparam int BRAM_MAX_DW = 1024;
   localparam int BRAM_MAX_NB = BRAM_MAX_DW / 8;

   function automatic logic [BRAM_MAX_DW-1:0] byte_merge(
      input logic [BRAM_MAX_DW-1:0] old_w,
      input logic [BRAM_MAX_DW-1:0] new_w,
      input logic [BRAM_MAX_NB-1:0] be
   );
      logic [BRAM_MAX_DW-1:0] m;
      m = old_w;
      for (int i = 0; i < BRAM_MAX_NB; i++) begin
         if (be[i]) begin
            m[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/bram_sdp_if.sv
// rtl/bram_sdp_if.sv - access bundle between a datapath client and bram_sdp
//
// Purpose : groups the clear request, write port, read port and status lines.
// Signals : clr            single-cycle request to re-run the clear sequence
//           we[NB]         byte write enables
//           waddr, wdi     write byte address and data
//           re, raddr      read enable and byte address
//           rdo, rvalid    read data and its one-cycle valid strobe
//           busy           clear sequence in progress
//           oor            one-cycle out-of-range pulse
// Modports: master = client side, slave = RAM side.

interface bram_sdp_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   localparam int NB = DATA_WIDTH / 8;

   logic                  clr;
   logic [NB-1:0]         we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdi;
   logic                  re;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] rdo;
   logic                  rvalid;
   logic                  busy;
   logic                  oor;

   modport master (
      output clr, we, waddr, wdi, re, raddr,
      input  rdo, rvalid, busy, oor
   );

   modport slave (
      input  clr, we, waddr, wdi, re, raddr,
      output rdo, rvalid, busy, oor
   );

endinterface

// File: rtl/bram_clr_seq.sv
// rtl/bram_clr_seq.sv - clear sequencer that zeroes the array word by word
//
// Purpose : two-state FSM (CLEAR/IDLE) with a word pointer. Starts in CLEAR
//           out of reset, walks ptr 0..DEPTH-1 writing zero words, then idles.
//           A clr request (in either state) restarts the walk at 0.
// Ports   : clk, rst (async, active high), clr (request),
//           busy (in CLEAR), clr_we (clear write strobe), clr_addr (word ptr).

module bram_clr_seq
   import bram_pkg::*;
#(
   parameter int DEPTH = 11,
   parameter int PW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          busy,
   output logic          clr_we,
   output logic [PW-1:0] clr_addr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   bram_state_t   state, state_d;
   logic [PW-1:0] ptr, ptr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_d;
         ptr   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      case (state)
         CLEAR: begin
            if (clr) begin
               ptr_d = '0;
            end else if (ptr == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr + 1'b1;
            end
         end
         default: begin
            if (clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
      endcase
   end

   assign busy     = (state == CLEAR);
   assign clr_we   = (state == CLEAR);
   assign clr_addr = ptr;

endmodule

// File: rtl/bram_sdp.sv
// rtl/bram_sdp.sv - simple-dual-port RAM with byte enables, bypass and clear
//
// Purpose : one write port, one read port, DEPTH words of DATA_WIDTH bits,
//           byte-addressed. Out-of-range accesses are dropped (write) or
//           return zero (read) and pulse oor. Same-address read and write
//           return the byte-merged new word. A clear sequencer owns the
//           write port while busy; user traffic is ignored during that time.
// Ports   : clk, rst (async, active high), bus (bram_sdp_if.slave).
// Config  : BRAM_SDP_OUTREG_EN adds an output register (read latency 2).

module bram_sdp
   import bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 11,
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   bram_sdp_if.slave  bus
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int AB = $clog2(NB);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

   logic          busy;
   logic          clr_we;
   logic [PW-1:0] clr_addr;

   bram_clr_seq #(.DEPTH(DEPTH), .PW(PW)) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic [ADDR_WIDTH-1:0] wword, rword;
   logic                  w_in, r_in;
   logic                  wr_req, wr_ok, rd_ok;

   assign wword  = bus.waddr >> AB;
   assign rword  = bus.raddr >> AB;
   assign w_in   = (wword < DEPTH_A);
   assign r_in   = (rword < DEPTH_A);
   assign wr_req = (|bus.we) && !busy;
   assign wr_ok  = wr_req && w_in;
   assign rd_ok  = bus.re && !busy;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] wr_merged, rd_old, rd_data;

   assign wr_merged = DATA_WIDTH'(byte_merge(BRAM_MAX_DW'(mem[wword[PW-1:0]]),
                                             BRAM_MAX_DW'(bus.wdi),
                                             BRAM_MAX_NB'(bus.we)));
   assign rd_old    = mem[rword[PW-1:0]];

   // Write-first: a same-word write this edge is folded into the read data.
   always_comb begin
      rd_data = rd_old;
      if (wr_ok && (wword == rword)) begin
         rd_data = DATA_WIDTH'(byte_merge(BRAM_MAX_DW'(rd_old),
                                          BRAM_MAX_DW'(bus.wdi),
                                          BRAM_MAX_NB'(bus.we)));
      end
   end

   // Storage has no reset; the clear sequencer defines its contents.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_ok) begin
         mem[wword[PW-1:0]] <= wr_merged;
      end
   end

   logic [DATA_WIDTH-1:0] rdo1;
   logic                  rv1, oor_rd1, oor_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdo1    <= '0;
         rv1     <= 1'b0;
         oor_rd1 <= 1'b0;
         oor_wr  <= 1'b0;
      end else begin
         rv1     <= rd_ok;
         oor_rd1 <= rd_ok && !r_in;
         oor_wr  <= wr_req && !w_in;
         if (rd_ok) begin
            rdo1 <= r_in ? rd_data : '0;
         end
      end
   end

`ifdef BRAM_SDP_OUTREG_EN
   logic [DATA_WIDTH-1:0] rdo2;
   logic                  rv2, oor_rd2;

   // Anything still in the first stage when CLEAR is active is flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdo2    <= '0;
         rv2     <= 1'b0;
         oor_rd2 <= 1'b0;
      end else begin
         rv2     <= rv1 && !busy;
         oor_rd2 <= oor_rd1 && !busy;
         if (rv1 && !busy) begin
            rdo2 <= rdo1;
         end
      end
   end

   assign bus.rdo    = rdo2;
   assign bus.rvalid = rv2;
   assign bus.oor    = oor_wr | oor_rd2;
`else
   assign bus.rdo    = rdo1;
   assign bus.rvalid = rv1;
   assign bus.oor    = oor_wr | oor_rd1;
`endif

   assign bus.busy = busy;

endmodule

// File: tb/tb_bram_sdp.sv
// tb/tb_bram_sdp.sv - scoreboard bench for bram_sdp against an array model

module tb_bram_sdp;

   localparam int AW    = 12;
   localparam int DEPTH = 11;
   localparam int DW    = 32;
   localparam int NB    = DW / 8;
`ifdef BRAM_SDP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      int          due;
      logic [31:0] data;
   } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bram_sdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bram_sdp #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] model_mem [DEPTH];
   int            left;
   int            cyc;
   int            tests;
   int            fails;
   rd_t           rd_q [$];
   bit            oor_exp [int];
   logic [DW-1:0] last_rdo;

   // Monitor: pops a read expectation whenever rvalid shows, checks oor every cycle.
   always @(negedge clk) begin
      rd_t  e;
      logic exp_o;
      if (!rst) begin
         tests++;
         if (bus.rvalid) begin
            if (rd_q.size() == 0) begin
               fails++;
               $display("FAIL rvalid_unexpected cyc=%0d rdo=%h", cyc, bus.rdo);
            end else begin
               e = rd_q.pop_front();
               last_rdo = e.data;
               if (e.due != cyc || bus.rdo !== e.data) begin
                  fails++;
                  $display("FAIL read_data cyc=%0d got=%h want=%h due=%0d", cyc, bus.rdo, e.data, e.due);
               end
            end
         end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            fails++;
            $display("FAIL rvalid_missing cyc=%0d want=%h due=%0d", cyc, rd_q[0].data, rd_q[0].due);
            rd_q.delete(0);
         end else if (bus.rdo !== last_rdo) begin
            fails++;
            $display("FAIL rdo_hold cyc=%0d got=%h want=%h", cyc, bus.rdo, last_rdo);
         end
         exp_o = oor_exp.exists(cyc) ? oor_exp[cyc] : 1'b0;
         tests++;
         if (bus.oor !== exp_o) begin
            fails++;
            $display("FAIL oor cyc=%0d got=%b want=%b", cyc, bus.oor, exp_o);
         end
      end
   end

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
   endtask

   // Drive one cycle of stimulus, update the model, then check busy after the edge.
   task automatic step(input bit c, input logic [NB-1:0] w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra);
      int            ww, rw;
      bit            idle;
      rd_t           e;
      logic [DW-1:0] d;
      bus.clr = c; bus.we = w; bus.waddr = wa; bus.wdi = wd; bus.re = r; bus.raddr = ra;
      idle = (left == 0);
      ww = int'(wa >> 2);
      rw = int'(ra >> 2);
      if (idle && r && !(LAT == 2 && c)) begin
         e.due = cyc + LAT;
         if (rw < DEPTH) begin
            d = model_mem[rw];
            if (w != 0 && ww == rw)
               for (int i = 0; i < NB; i++) if (w[i]) d[8*i +: 8] = wd[8*i +: 8];
            e.data = d;
         end else begin
            e.data = '0;
            oor_exp[cyc + LAT] = 1'b1;
         end
         rd_q.push_back(e);
      end
      if (idle && w != 0) begin
         if (ww < DEPTH) begin
            for (int i = 0; i < NB; i++) if (w[i]) model_mem[ww][8*i +: 8] = wd[8*i +: 8];
         end else begin
            oor_exp[cyc + 1] = 1'b1;
         end
      end
      if (c) begin
         left = DEPTH;
         zero_model();
      end else if (left > 0) begin
         left--;
      end
      @(posedge clk);
      #1;
      cyc++;
      tests++;
      if (bus.busy !== (left > 0)) begin
         fails++;
         $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, (left > 0));
      end
   endtask

   task automatic rstep(input int pclr);
      logic [NB-1:0] w;
      w = ($urandom_range(0, 1) == 1) ? NB'($urandom_range(1, 15)) : '0;
      step($urandom_range(0, 99) < pclr, w, AW'($urandom_range(0, (DEPTH + 2) * 4 - 1)),
           $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, (DEPTH + 2) * 4 - 1)));
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i * 4));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.clr = 1'b0; bus.we = '0; bus.re = 1'b0;
      #1;
      tests += 4;
      if (bus.rdo !== '0)     begin fails++; $display("FAIL reset_rdo got=%h want=0", bus.rdo); end
      if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got=%b want=0", bus.rvalid); end
      if (bus.oor !== 1'b0)   begin fails++; $display("FAIL reset_oor got=%b want=0", bus.oor); end
      if (bus.busy !== 1'b1)  begin fails++; $display("FAIL reset_busy got=%b want=1", bus.busy); end
      last_rdo = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b0;
      left = DEPTH;
      zero_model();
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; left = DEPTH; last_rdo = '0;
      bus.clr = 1'b0; bus.we = '0; bus.waddr = '0; bus.wdi = '0; bus.re = 1'b0; bus.raddr = '0;
      @(posedge clk);
      #1;
      cyc++;
      do_reset();
      repeat (DEPTH) rstep(0);
      read_all();

      step(1'b0, 4'hF,    12'h008, 32'hAABBCCDD, 1'b0, '0);
      step(1'b0, 4'b0101, 12'h008, 32'h11223344, 1'b0, '0);
      step(1'b0, 4'h0,    '0,      '0,           1'b1, 12'h008);
      step(1'b0, 4'hF,    12'h004, 32'hFFFFFFFF, 1'b0, '0);
      step(1'b0, 4'b0001, 12'h004, 32'h00000012, 1'b1, 12'h004);
      step(1'b0, 4'hF,    12'h02C, 32'hDEADBEEF, 1'b0, '0);
      step(1'b0, 4'h0,    '0,      '0,           1'b1, 12'h02C);
      step(1'b0, 4'h0,    '0,      '0,           1'b1, 12'h02B);
      step(1'b0, 4'hF,    12'hFFC, 32'h12345678, 1'b1, 12'hFFF);
      step(1'b0, 4'h0,    '0,      '0,           1'b1, 12'h028);
      read_all();

      repeat (400) rstep(0);

      for (int i = 0; i < DEPTH; i++) step(1'b0, 4'hF, AW'(i * 4), $urandom, 1'b0, '0);
      step(1'b1, '0, '0, '0, 1'b0, '0);
      repeat (DEPTH) rstep(0);
      read_all();

      repeat (300) rstep(3);
      while (left > 0) step(1'b0, '0, '0, '0, 1'b0, '0);
      read_all();

      for (int i = 0; i < DEPTH; i++) step(1'b0, 4'hF, AW'(i * 4), $urandom, 1'b0, '0);
      step(1'b1, '0, '0, '0, 1'b0, '0);
      repeat (5) step(1'b0, '0, '0, '0, 1'b0, '0);
      do_reset();
      repeat (DEPTH) rstep(0);
      read_all();

      repeat (LAT + 3) step(1'b0, '0, '0, '0, 1'b0, '0);
      tests++;
      if (rd_q.size() != 0) begin
         fails++;
         $display("FAIL reads_outstanding got=%0d want=0", rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
